uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
Parametrised successor to the single-buffer serial port: a bus-slave UART with TX and RX FIFOs of configurable depth and runtime-selectable parity and stop bits. It also adds a 16x-oversampled receiver with glitch rejection, sticky error flags and a maskable level interrupt. It sits on the same 32-bit word-addressed slave bus as the other peripherals and drives the CPU's external interrupt line.

Parameters:
FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, 2..128.
DIV_RESET, 16'd325, reset value of the 16x baud divisor (50 MHz clock, 9600 baud).

Ports:
CLK_I  input  1  clock, all logic on posedge.
RST_I  input  1  reset, asynchronous, active-high.
ADD_I  input  3  word address [4:2].
DAT_I  input  32  write data.
DAT_O  output  32  read data, combinational from ADD_I.
STB_I  input  1  strobe.
WE_I  input  1  write enable.
ACK_O  output  1  equals STB_I, so every access is zero-wait.
RxD  input  1  serial in, asynchronous.
TxD  output  1  serial out.
Interrupt  output  1  level interrupt.

Behaviour:
- Register map (ADD_I):
  - 0 DATA: a write pushes DAT_I[7:0] to the TX FIFO. A read returns {24'b0, RX head}; the pop happens on the edge where STB_I & !WE_I.
  - 1 IER[2:0]: RW.
  - 2 LSR: RO.
  - 3 LCR[2:0]: RW. [1:0] parity: 00 none, 01 odd, 10 even, 11 none. [2]: two stop bits.
  - 4 DIV[15:0]: RW.
  - 5 CNT: RO, {16'b0, tx_count[7:0], rx_count[7:0]}.
  - 6, 7: read 0, writes ignored.
- LSR bit map: [0] rx_nonempty, [1] overrun, [2] parity_err, [3] frame_err, [4] tx_empty, [5] tx_idle (FIFO empty and FSM IDLE), [6] tx_full, [7] tx_overflow.
  - Bits [1],[2],[3],[7] are sticky. They clear on the edge of an LSR read; a new error set on that same edge wins.
- Reset values: TxD=1, Interrupt=0, FIFOs empty, IER=0, LCR=0, DIV=DIV_RESET, all flags 0, both FSMs IDLE, tick counter 0.
- Baud tick:
  - A 16-bit counter runs 0..max(DIV,1)-1; a one-cycle tick pulses at terminal count.
  - A DIV write loads the new value and clears the counter.
- TX FSM: IDLE -> START -> DATA(8) -> [PARITY] -> STOP(1|2) -> IDLE.
  - Each bit lasts 16 ticks. Data goes out LSB first.
  - IDLE pops the FIFO on a tick when it is non-empty; START begins on that tick.
  - Parity is the XOR of the data bits, inverted for odd parity.
  - LCR is sampled at the pop and held for the frame.
  - From STOP with the FIFO non-empty, the FSM goes straight to the next START, so frames are back-to-back.
- RX path:
  - RxD passes through a 2-FF synchroniser.
  - IDLE waits for a low sample on a tick. Then 8 ticks later: if still low go to DATA, else return to IDLE (glitch rejected).
  - Data, parity and one stop bit are each sampled 16 ticks after the previous sample.
  - A parity mismatch sets parity_err. A stop bit of 0 sets frame_err.
  - The byte is pushed regardless of errors. If the FIFO is full, the byte is dropped and overrun is set.
  - After the stop-bit sample the FSM returns to IDLE.
- FIFOs:
  - Circular, with pointers of log2(FIFO_DEPTH) bits plus a count of log2(FIFO_DEPTH)+1 bits.
  - Pop when empty: ignored, and DAT_O reads the last head entry.
  - Push when full: dropped. On TX this sets tx_overflow.
  - Push and pop on the same edge: both occur and the count is unchanged. This holds when full (the pop frees the slot) but not when empty, where only the push takes effect.
- Interrupt = (IER[0] & rx_nonempty) | (IER[1] & tx_empty) | (IER[2] & (overrun | parity_err | frame_err)). It is registered, so it lags its cause by one cycle.
- Reset mid-frame: TxD goes to 1 asynchronously, any partial RX byte is discarded, and FIFO contents are lost.
- Writing DIV or LCR mid-frame takes effect at the next tick and the next frame respectively. Software must not do this; behaviour is defined but no frame integrity is guaranteed.

Test Plan:
1. Loopback at DIV=1, TxD tied to RxD, LCR=0: write 0x55, 0xA3, 0x00 to DATA -> after 3*160 ticks CNT reads rx=3, reads return 0x55, 0xA3, 0x00 in order, and LSR[3:1]=0.
2. LCR=2'b10 (even parity) loopback of 0x07 -> the parity bit on TxD is 1, the frame is 11 bit-times, and parity_err=0. Then force the RX parity bit low -> LSR[2]=1, and the second LSR read returns LSR[2]=0.
3. FIFO_DEPTH=4 with RX never read: send 6 bytes -> CNT rx=4, overrun=1, and the reads return the first 4 bytes.
4. Write 5 bytes with FIFO_DEPTH=4 while the TX FSM is busy -> tx_full=1, tx_overflow=1, and exactly 4 + 1 (already popped) frames appear on TxD.
5. IER=3'b001: RxD frame 0x3C -> Interrupt rises within 1 cycle of the push; reading DATA drops it on the next cycle. Drive a 4-tick low pulse on RxD -> no byte is received.
6. Assert RST_I asynchronously mid-TX-frame -> TxD=1 the same cycle, CNT=0, DIV=325, and LSR=8'h30.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo: bus-slave UART with TX/RX FIFOs, 16x oversampled receiver,
// runtime parity/stop selection, sticky line errors and a level interrupt.

module uart_fifo_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          dropped
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // a full FIFO still accepts a push when the same edge frees a slot
    assign do_push = push & (~full | do_pop);
    assign dropped = push & ~do_push;
    assign rdata   = mem[rd_ptr];

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_fifo #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd325
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [2:0]  ADD_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    input  logic        STB_I,
    input  logic        WE_I,
    output logic        ACK_O,
    input  logic        RxD,
    output logic        TxD,
    output logic        Interrupt
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // bus decode
    logic wr, rd, tx_push, rx_pop, lsr_rd, ier_wr, lcr_wr, div_wr;
    assign ACK_O   = STB_I;
    assign wr      = STB_I & WE_I;
    assign rd      = STB_I & ~WE_I;
    assign tx_push = wr & (ADD_I == 3'd0);
    assign ier_wr  = wr & (ADD_I == 3'd1);
    assign lcr_wr  = wr & (ADD_I == 3'd3);
    assign div_wr  = wr & (ADD_I == 3'd4);
    assign rx_pop  = rd & (ADD_I == 3'd0);
    assign lsr_rd  = rd & (ADD_I == 3'd2);

    logic unused_dat;
    assign unused_dat = ^DAT_I[31:16];

    logic [2:0]  ier;
    logic [2:0]  lcr;
    logic [15:0] div;

    // control registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ier <= '0;
            lcr <= '0;
            div <= DIV_RESET;
        end else begin
            if (ier_wr) ier <= DAT_I[2:0];
            if (lcr_wr) lcr <= DAT_I[2:0];
            if (div_wr) div <= DAT_I[15:0];
        end
    end

    // baud tick generator: one pulse every max(DIV,1) clocks
    logic [15:0] baud_cnt;
    logic [15:0] div_eff;
    logic        tick;
    assign div_eff = (div == 16'd0) ? 16'd1 : div;
    assign tick    = (baud_cnt == div_eff - 16'd1);

    // baud counter, restarted on any divisor write
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)               baud_cnt <= '0;
        else if (div_wr || tick) baud_cnt <= '0;
        else                     baud_cnt <= baud_cnt + 16'd1;
    end

    // FIFOs
    logic [7:0]  tx_rdata, rx_rdata, rx_shift;
    logic [AW:0] tx_count, rx_count;
    logic        tx_empty, tx_full, tx_drop, tx_pop;
    logic        rx_empty, rx_full, rx_drop, rx_push;

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_tx_fifo (
        .clk(CLK_I), .rst(RST_I), .push(tx_push), .pop(tx_pop), .wdata(DAT_I[7:0]),
        .rdata(tx_rdata), .count(tx_count), .empty(tx_empty), .full(tx_full), .dropped(tx_drop)
    );

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_rx_fifo (
        .clk(CLK_I), .rst(RST_I), .push(rx_push), .pop(rx_pop), .wdata(rx_shift),
        .rdata(rx_rdata), .count(rx_count), .empty(rx_empty), .full(rx_full), .dropped(rx_drop)
    );

    // ---------------- transmitter ----------------
    tx_state_t  tx_state, tx_next;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bitn;
    logic [7:0] tx_shift;
    logic       tx_par, tx_par_en, tx_two_stop, tx_stop_cnt;
    logic       tx_bit_end, tx_last_stop;

    assign tx_bit_end   = tick & (tx_tcnt == 4'd15);
    assign tx_last_stop = ~tx_two_stop | tx_stop_cnt;
    assign tx_pop = ~tx_empty & (((tx_state == TX_IDLE) & tick) |
                                 ((tx_state == TX_STOP) & tx_bit_end & tx_last_stop));

    // TX state register
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    // TX next-state logic
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tick && !tx_empty) tx_next = TX_START;
            TX_START:  if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_bitn == 3'd7) tx_next = tx_par_en ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
            TX_STOP:   if (tx_bit_end && tx_last_stop) tx_next = tx_empty ? TX_IDLE : TX_START;
            default:   tx_next = TX_IDLE;
        endcase
    end

    // TX line output
    always_comb begin
        TxD = 1'b1;
        case (tx_state)
            TX_START:  TxD = 1'b0;
            TX_DATA:   TxD = tx_shift[0];
            TX_PARITY: TxD = tx_par;
            default:   TxD = 1'b1;
        endcase
    end

    // TX datapath: frame setup at pop, bit timing and shifting
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            tx_tcnt     <= '0;
            tx_bitn     <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_par_en   <= 1'b0;
            tx_two_stop <= 1'b0;
            tx_stop_cnt <= 1'b0;
        end else if (tx_pop) begin
            tx_shift    <= tx_rdata;
            tx_par      <= (^tx_rdata) ^ (lcr[1:0] == 2'b01);
            tx_par_en   <= lcr[1] ^ lcr[0];
            tx_two_stop <= lcr[2];
            tx_tcnt     <= '0;
            tx_bitn     <= '0;
            tx_stop_cnt <= 1'b0;
        end else if (tick && tx_state != TX_IDLE) begin
            tx_tcnt <= tx_tcnt + 4'd1;
            if (tx_tcnt == 4'd15) begin
                if (tx_state == TX_DATA) begin
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bitn  <= tx_bitn + 3'd1;
                end
                if (tx_state == TX_STOP) tx_stop_cnt <= 1'b1;
            end
        end
    end

    // ---------------- receiver ----------------
    logic rx_meta, rx_sync;

    // two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rx_sync <= rx_meta;
        end
    end

    rx_state_t  rx_state, rx_next;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bitn;
    logic       rx_par_en, rx_odd, rx_sample;
    logic       par_set, frm_set;

    assign rx_sample = tick & (rx_tcnt == 4'd15);

    // RX state register
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    // RX next-state logic, start bit re-checked mid-bit to reject glitches
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (tick && !rx_sync) rx_next = RX_START;
            RX_START:  if (tick && rx_tcnt == 4'd7) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample && rx_bitn == 3'd7) rx_next = rx_par_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_sample) rx_next = RX_STOP;
            RX_STOP:   if (rx_sample) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    // RX outputs: FIFO push and error strobes
    always_comb begin
        rx_push = 1'b0;
        par_set = 1'b0;
        frm_set = 1'b0;
        case (rx_state)
            RX_PARITY: par_set = rx_sample & (rx_sync != ((^rx_shift) ^ rx_odd));
            RX_STOP: begin
                rx_push = rx_sample;
                frm_set = rx_sample & ~rx_sync;
            end
            default: ;
        endcase
    end

    // RX datapath: tick counting, LCR capture and data shifting
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rx_tcnt   <= '0;
            rx_bitn   <= '0;
            rx_shift  <= '0;
            rx_par_en <= 1'b0;
            rx_odd    <= 1'b0;
        end else if (tick) begin
            case (rx_state)
                RX_IDLE: rx_tcnt <= '0;
                RX_START: begin
                    if (rx_tcnt == 4'd7) begin
                        rx_tcnt   <= '0;
                        rx_bitn   <= '0;
                        rx_par_en <= lcr[1] ^ lcr[0];
                        rx_odd    <= (lcr[1:0] == 2'b01);
                    end else begin
                        rx_tcnt <= rx_tcnt + 4'd1;
                    end
                end
                RX_DATA: begin
                    rx_tcnt <= rx_tcnt + 4'd1;
                    if (rx_tcnt == 4'd15) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bitn  <= rx_bitn + 3'd1;
                    end
                end
                default: rx_tcnt <= rx_tcnt + 4'd1;
            endcase
        end
    end

    // ---------------- status, interrupt, read mux ----------------
    logic overrun, parity_err, frame_err, tx_overflow, tx_idle;
    logic [7:0] lsr;

    // sticky error flags; a set on the clearing edge wins
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            overrun     <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            overrun     <= rx_drop | (overrun     & ~lsr_rd);
            parity_err  <= par_set | (parity_err  & ~lsr_rd);
            frame_err   <= frm_set | (frame_err   & ~lsr_rd);
            tx_overflow <= tx_drop | (tx_overflow & ~lsr_rd);
        end
    end

    assign tx_idle = tx_empty & (tx_state == TX_IDLE);
    assign lsr = {tx_overflow, tx_full, tx_idle, tx_empty, frame_err, parity_err, overrun, ~rx_empty};

    // registered level interrupt
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) Interrupt <= 1'b0;
        else Interrupt <= (ier[0] & ~rx_empty) | (ier[1] & tx_empty) |
                          (ier[2] & (overrun | parity_err | frame_err));
    end

    // combinational read data
    always_comb begin
        DAT_O = '0;
        case (ADD_I)
            3'd0:    DAT_O = {24'b0, rx_rdata};
            3'd1:    DAT_O = {29'b0, ier};
            3'd2:    DAT_O = {24'b0, lsr};
            3'd3:    DAT_O = {29'b0, lcr};
            3'd4:    DAT_O = {16'b0, div};
            3'd5:    DAT_O = {16'b0, 8'(tx_count), 8'(rx_count)};
            default: DAT_O = '0;
        endcase
    end

    logic unused_flags;
    assign unused_flags = rx_full;
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed scoreboard bench for uart_fifo (FIFO_DEPTH=4, DIV=1).

module tb_uart_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  add = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic        ack;
    logic        rxd;
    logic        txd;
    logic        irq;

    logic        loop = 1'b0;
    logic        rxd_drv = 1'b1;
    logic [1:0]  tb_lcr = 2'b00;
    logic        mon_en = 1'b1;
    logic        last_par = 1'b0;

    logic [7:0]  rx_exp[$];
    logic [7:0]  tx_exp[$];
    logic [8:0]  tx_seen[$];

    int n_assert = 0;
    int n_fail = 0;

    assign rxd = loop ? txd : rxd_drv;

    uart_fifo #(.FIFO_DEPTH(4)) dut (
        .CLK_I(clk), .RST_I(rst), .ADD_I(add), .DAT_I(dat_i), .DAT_O(dat_o),
        .STB_I(stb), .WE_I(we), .ACK_O(ack), .RxD(rxd), .TxD(txd), .Interrupt(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        add = a; dat_i = d; we = 1'b1; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        add = a; we = 1'b0; stb = 1'b1;
        #1 d = dat_o;
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic peek(input logic [2:0] a, output logic [31:0] d);
        add = a;
        #1 d = dat_o;
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] d;
        logic [7:0]  e;
        bus_rd(3'd0, d);
        if (rx_exp.size() == 0) e = 8'hxx;
        else e = rx_exp.pop_front();
        chk(tag, d, {24'b0, e});
    endtask

    task automatic check_tx(input string tag);
        logic [8:0] s;
        logic [7:0] e;
        chk({tag, "_count"}, tx_seen.size(), tx_exp.size());
        while (tx_seen.size() > 0 && tx_exp.size() > 0) begin
            s = tx_seen.pop_front();
            e = tx_exp.pop_front();
            chk(tag, {23'b0, s}, {23'b0, 1'b1, e});
        end
        tx_seen.delete();
        tx_exp.delete();
    endtask

    task automatic send_rx(input logic [7:0] b, input logic [1:0] pm, input logic flip);
        logic p;
        p = (^b) ^ (pm == 2'b01);
        if (flip) p = ~p;
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (16) @(negedge clk);
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            rxd_drv = p;
            repeat (16) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (32) @(negedge clk);
    endtask

    task automatic wait_txd_low(input string tag);
        int n;
        n = 0;
        while (txd !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, txd === 1'b0}, 32'd1);
    endtask

    // TX line monitor, decoding frames at DIV=1 (16 clocks per bit)
    logic [7:0] mb;
    logic       ms;
    initial begin
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (8) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    mb[i] = txd;
                end
                if (tb_lcr == 2'b01 || tb_lcr == 2'b10) begin
                    repeat (16) @(negedge clk);
                    last_par = txd;
                end
                repeat (16) @(negedge clk);
                ms = txd;
                if (mon_en) tx_seen.push_back({ms, mb});
            end
        end
    end

    initial begin
        logic [31:0] d;
        int k;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_txd", {31'b0, txd}, 32'd1);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        peek(3'd2, d); chk("rst_lsr", d, 32'h30);
        peek(3'd5, d); chk("rst_cnt", d, 32'h0);
        peek(3'd4, d); chk("rst_div", d, 32'd325);
        @(negedge clk);
        rst = 1'b0;
        peek(3'd1, d); chk("rst_ier", d, 32'h0);
        peek(3'd3, d); chk("rst_lcr", d, 32'h0);
        bus_wr(3'd6, 32'hFFFF_FFFF);
        peek(3'd6, d); chk("addr6_zero", d, 32'h0);
        chk("ack_follows_stb", {31'b0, ack}, {31'b0, stb});

        bus_wr(3'd4, 32'd1);
        peek(3'd4, d); chk("div_rw", d, 32'd1);

        // loopback of three bytes, no parity
        loop = 1'b1;
        bus_wr(3'd0, 32'h55); rx_exp.push_back(8'h55); tx_exp.push_back(8'h55);
        bus_wr(3'd0, 32'hA3); rx_exp.push_back(8'hA3); tx_exp.push_back(8'hA3);
        bus_wr(3'd0, 32'h00); rx_exp.push_back(8'h00); tx_exp.push_back(8'h00);
        repeat (600) @(negedge clk);
        peek(3'd5, d); chk("lb_cnt", d, 32'h3);
        peek(3'd2, d); chk("lb_err", (d >> 1) & 32'h7, 32'h0);
        rd_data("lb_rd0");
        rd_data("lb_rd1");
        rd_data("lb_rd2");
        peek(3'd5, d); chk("lb_cnt_after", d, 32'h0);
        check_tx("lb_tx");

        // even parity loopback and frame length
        bus_wr(3'd3, 32'h2); tb_lcr = 2'b10;
        peek(3'd3, d); chk("lcr_rw", d, 32'h2);
        bus_wr(3'd0, 32'h07); rx_exp.push_back(8'h07); tx_exp.push_back(8'h07);
        wait_txd_low("par_start_timeout");
        add = 3'd2;
        k = 0;
        #1;
        while (dat_o[5] !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("par_frame_len", k, 32'd176);
        repeat (20) @(negedge clk);
        chk("par_bit", {31'b0, last_par}, 32'd1);
        peek(3'd2, d); chk("par_ok", (d >> 2) & 32'h1, 32'h0);
        rd_data("par_rd");
        check_tx("par_tx");

        // corrupted parity bit on RX
        loop = 1'b0;
        send_rx(8'h07, 2'b10, 1'b1); rx_exp.push_back(8'h07);
        bus_rd(3'd2, d); chk("par_err_set", (d >> 2) & 32'h1, 32'h1);
        bus_rd(3'd2, d); chk("par_err_clr", (d >> 2) & 32'h1, 32'h0);
        rd_data("par_bad_rd");

        // RX overrun with depth 4
        bus_wr(3'd3, 32'h0); tb_lcr = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            send_rx(8'(i * 8'h11), 2'b00, 1'b0);
            if (i <= 4) rx_exp.push_back(8'(i * 8'h11));
        end
        peek(3'd5, d); chk("ovr_cnt", d, 32'h4);
        peek(3'd2, d); chk("ovr_flag", (d >> 1) & 32'h1, 32'h1);
        peek(3'd2, d); chk("ovr_frame_ok", (d >> 3) & 32'h1, 32'h0);
        rd_data("ovr_rd0");
        rd_data("ovr_rd1");
        rd_data("ovr_rd2");
        rd_data("ovr_rd3");
        bus_rd(3'd2, d);
        peek(3'd2, d); chk("ovr_clr", (d >> 1) & 32'h1, 32'h0);

        // TX overflow while a frame is in flight
        bus_wr(3'd0, 32'hC1); tx_exp.push_back(8'hC1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus_wr(3'd0, 32'(8'hD0 + 8'(i)));
            if (i < 4) tx_exp.push_back(8'hD0 + 8'(i));
        end
        peek(3'd2, d); chk("txof_flags", (d >> 6) & 32'h3, 32'h3);
        peek(3'd5, d); chk("txof_cnt", d, 32'h0400);
        add = 3'd2;
        k = 0;
        #1;
        while (dat_o[5] !== 1'b1 && k < 1200) begin
            @(negedge clk);
            k++;
        end
        chk("txof_idle_timeout", {31'b0, k < 1200}, 32'd1);
        repeat (4) @(negedge clk);
        check_tx("txof_tx");

        // interrupt on RX data, then glitch rejection
        bus_wr(3'd1, 32'h1);
        rx_exp.push_back(8'h3C);
        fork
            send_rx(8'h3C, 2'b00, 1'b0);
        join_none
        add = 3'd2;
        k = 0;
        #1;
        while (dat_o[0] !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("irq_push_timeout", {31'b0, k < 400}, 32'd1);
        chk("irq_lag", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_rise", {31'b0, irq}, 32'd1);
        repeat (60) @(negedge clk);
        rd_data("irq_rd");
        chk("irq_hold", {31'b0, irq}, 32'd1);
        @(negedge clk);
        chk("irq_drop", {31'b0, irq}, 32'd0);
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (200) @(negedge clk);
        peek(3'd5, d); chk("glitch_cnt", d, 32'h0);

        // asynchronous reset in the middle of a TX frame
        mon_en = 1'b0;
        bus_wr(3'd0, 32'h00);
        wait_txd_low("rst_start_timeout");
        repeat (50) @(negedge clk);
        chk("mid_txd", {31'b0, txd}, 32'd0);
        #3 rst = 1'b1;
        #1 chk("async_txd", {31'b0, txd}, 32'd1);
        peek(3'd5, d); chk("async_cnt", d, 32'h0);
        peek(3'd4, d); chk("async_div", d, 32'd325);
        peek(3'd2, d); chk("async_lsr", d, 32'h30);
        chk("async_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        peek(3'd1, d); chk("post_rst_ier", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
